// File: rtl/i2s_tx_if.sv
// Sample-write and I2S line bundle for i2s_tx.
// master = sample producer / line observer, slave = the transmitter.
interface i2s_tx_if;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ch;
  logic        bclk;
  logic        lrck;
  logic        sdata;
  logic        l_r_edge;
  logic        underrun;

  modport master (
    output sample_in, sample_valid, sample_ch,
    input  bclk, lrck, sdata, l_r_edge, underrun
  );

  modport slave (
    input  sample_in, sample_valid, sample_ch,
    output bclk, lrck, sdata, l_r_edge, underrun
  );
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: 16-bit stereo samples into SLOT_BITS-wide slots, MSB first, one-bit delay.
// Each channel has a hold register and a pending flag; a slot load with no fresh sample flags underrun.
module i2s_tx #(
  parameter int unsigned BCLK_HALF = 2,
  parameter int unsigned SLOT_BITS = 32
) (
  input logic     clk,
  input logic     reset,
  i2s_tx_if.slave bus
);

  localparam int unsigned DivW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int unsigned BitW = $clog2(SLOT_BITS);
  localparam logic [DivW-1:0] DivLast = DivW'(BCLK_HALF - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(SLOT_BITS - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(16);

  logic [DivW-1:0]       r_div_cnt, w_div_cnt_d;
  logic                  r_bclk, w_bclk_d;
  logic [BitW-1:0]       r_bit_cnt, w_bit_cnt_d;
  logic                  r_lrck, w_lrck_d;
  logic                  r_sdata, w_sdata_d;
  logic                  r_l_r_edge, w_l_r_edge_d;
  logic                  r_underrun, w_underrun_d;
  logic [15:0]           r_shift, w_shift_d;
  logic [1:0][15:0]      r_hold, w_hold_d;
  logic [1:0]            r_pending, w_pending_d;

  logic                  w_div_wrap;
  logic                  w_fall;
  logic                  w_slot_wrap;
  logic                  w_load;
  logic                  w_load_ch;
  logic [BitW-1:0]       w_bit_nxt;

  assign w_div_wrap  = (r_div_cnt == DivLast);
  assign w_fall      = w_div_wrap & r_bclk;
  assign w_slot_wrap = (r_bit_cnt == BitLast);
  assign w_bit_nxt   = w_slot_wrap ? '0 : r_bit_cnt + BitW'(1);
  assign w_load      = w_fall & w_slot_wrap;
  assign w_load_ch   = ~r_lrck;

  always_comb begin
    w_div_cnt_d  = w_div_wrap ? '0 : r_div_cnt + DivW'(1);
    w_bclk_d     = r_bclk ^ w_div_wrap;
    w_bit_cnt_d  = r_bit_cnt;
    w_lrck_d     = r_lrck;
    w_sdata_d    = r_sdata;
    w_shift_d    = r_shift;
    w_l_r_edge_d = 1'b0;
    w_underrun_d = 1'b0;
    w_hold_d     = r_hold;
    w_pending_d  = r_pending;

    if (w_fall) begin
      w_bit_cnt_d = w_bit_nxt;
      if (w_load) begin
        // Slot start: bit 0 is the I2S delay bit, so the MSB goes out on the next event.
        w_lrck_d                = ~r_lrck;
        w_l_r_edge_d            = 1'b1;
        w_shift_d               = r_hold[w_load_ch];
        w_underrun_d            = ~r_pending[w_load_ch];
        w_pending_d[w_load_ch]  = 1'b0;
        w_sdata_d               = 1'b0;
      end else if (w_bit_nxt <= DataLast) begin
        w_sdata_d = r_shift[15];
        w_shift_d = {r_shift[14:0], 1'b0};
      end else begin
        w_sdata_d = 1'b0;
      end
    end

    // Applied after the load so a same-cycle write is kept for the following slot.
    if (bus.sample_valid) begin
      w_hold_d[bus.sample_ch]    = bus.sample_in;
      w_pending_d[bus.sample_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div_cnt  <= '0;
      r_bclk     <= 1'b0;
      r_bit_cnt  <= BitLast;
      r_lrck     <= 1'b1;
      r_sdata    <= 1'b0;
      r_l_r_edge <= 1'b0;
      r_underrun <= 1'b0;
      r_shift    <= '0;
      r_hold     <= '0;
      r_pending  <= '0;
    end else begin
      r_div_cnt  <= w_div_cnt_d;
      r_bclk     <= w_bclk_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_lrck     <= w_lrck_d;
      r_sdata    <= w_sdata_d;
      r_l_r_edge <= w_l_r_edge_d;
      r_underrun <= w_underrun_d;
      r_shift    <= w_shift_d;
      r_hold     <= w_hold_d;
      r_pending  <= w_pending_d;
    end
  end

  assign bus.bclk     = r_bclk;
  assign bus.lrck     = r_lrck;
  assign bus.sdata    = r_sdata;
  assign bus.l_r_edge = r_l_r_edge;
  assign bus.underrun = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: line behaviour predicted from elapsed clk edges since reset release,
// slot contents from per-channel hold/pending bookkeeping.
module tb_i2s_tx;
  localparam int H  = 2;
  localparam int SB = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  i2s_tx_if bus ();

  i2s_tx #(.BCLK_HALF(H), .SLOT_BITS(SB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          n;
  logic [15:0] m_hold [2];
  bit   [1:0]  m_pend;
  logic [15:0] m_word;
  logic        e_bclk, e_lrck, e_sdata, e_edge, e_under;
  bit          bits[$];
  logic        prev_bclk;

  function automatic bit is_slot_start(int t);
    return (t > 0) && (t % (2 * H) == 0) && (((t / (2 * H)) - 1) % SB == 0);
  endfunction

  function automatic int slot_ch(int t);
    return (((t / (2 * H)) - 1) / SB) % 2;
  endfunction

  function automatic void calc_exp();
    int m;
    int k;
    e_bclk = ((n / H) % 2) == 1;
    if (n < 2 * H) begin
      e_lrck  = 1'b1;
      e_sdata = 1'b0;
    end else begin
      m       = n / (2 * H);
      k       = (m - 1) % SB;
      e_lrck  = ((((m - 1) / SB) % 2) == 1);
      e_sdata = (k >= 1 && k <= 16) ? m_word[16 - k] : 1'b0;
    end
  endfunction

  function automatic logic [31:0] slot_word(int s);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) w[31 - i] = bits[s * 32 + i];
    return w;
  endfunction

  task automatic tick();
    logic        v, c, rst;
    logic [15:0] d;
    int          ch;
    v = bus.sample_valid; c = bus.sample_ch; d = bus.sample_in; rst = reset;
    prev_bclk = bus.bclk;
    @(posedge clk);
    e_edge = 1'b0; e_under = 1'b0;
    if (!rst) begin
      n = 0; m_hold[0] = '0; m_hold[1] = '0; m_pend = '0; m_word = '0;
      bits.delete();
    end else begin
      n++;
      if (is_slot_start(n)) begin
        ch = slot_ch(n);
        m_word = m_hold[ch];
        e_under = !m_pend[ch];
        m_pend[ch] = 1'b0;
        e_edge = 1'b1;
      end
      if (v) begin
        m_hold[c] = d;
        m_pend[c] = 1'b1;
      end
    end
    calc_exp();
    #1;
    if (rst && n > 2 * H && prev_bclk === 1'b0 && bus.bclk === 1'b1) bits.push_back(bus.sdata);
  endtask

  task automatic do_reset();
    reset = 1'b0; bus.sample_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic write(input logic ch, input logic [15:0] d);
    bus.sample_valid = 1'b1; bus.sample_ch = ch; bus.sample_in = d;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.sample_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.bclk !== 1'b0) begin errors++; $display("FAIL reset_bclk got %b exp 0", bus.bclk); end
      checks++; if (bus.lrck !== 1'b1) begin errors++; $display("FAIL reset_lrck got %b exp 1", bus.lrck); end
      checks++; if (bus.sdata !== 1'b0) begin errors++; $display("FAIL reset_sdata got %b exp 0", bus.sdata); end
      checks++; if (bus.l_r_edge !== 1'b0) begin errors++; $display("FAIL reset_edge got %b exp 0", bus.l_r_edge); end
      checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b exp 0", bus.underrun); end
    end
  endtask

  task automatic test_stream();
    int under_cnt;
    under_cnt = 0;
    reset = 1'b1;
    write(1'b0, 16'hA5C3);
    write(1'b1, 16'h1234);
    while (n < 4 + 2 * 128 + 6) begin
      tick();
      if (n == 4) begin
        checks++;
        if (bus.lrck !== 1'b0 || bus.l_r_edge !== 1'b1) begin
          errors++; $display("FAIL stream_first_edge lrck %b edge %b exp 0 1", bus.lrck, bus.l_r_edge);
        end
      end
      if (n < 4 + 256 && bus.underrun === 1'b1) under_cnt++;
      checks++; if (bus.bclk !== e_bclk) begin errors++; $display("FAIL stream_bclk n=%0d got %b exp %b", n, bus.bclk, e_bclk); end
      checks++; if (bus.lrck !== e_lrck) begin errors++; $display("FAIL stream_lrck n=%0d got %b exp %b", n, bus.lrck, e_lrck); end
      checks++; if (bus.sdata !== e_sdata) begin errors++; $display("FAIL stream_sdata n=%0d got %b exp %b", n, bus.sdata, e_sdata); end
      checks++; if (bus.l_r_edge !== e_edge) begin errors++; $display("FAIL stream_edge n=%0d got %b exp %b", n, bus.l_r_edge, e_edge); end
      checks++; if (bus.underrun !== e_under) begin errors++; $display("FAIL stream_underrun n=%0d got %b exp %b", n, bus.underrun, e_under); end
    end
    checks++;
    if (bits.size() < 64) begin
      errors++; $display("FAIL stream_bitcount got %0d exp >= 64", bits.size());
    end else begin
      if (slot_word(0) !== {1'b0, 16'hA5C3, 15'h0}) begin
        errors++; $display("FAIL stream_left got %h exp %h", slot_word(0), {1'b0, 16'hA5C3, 15'h0});
      end
      checks++;
      if (slot_word(1) !== {1'b0, 16'h1234, 15'h0}) begin
        errors++; $display("FAIL stream_right got %h exp %h", slot_word(1), {1'b0, 16'h1234, 15'h0});
      end
    end
    checks++; if (under_cnt != 0) begin errors++; $display("FAIL stream_no_underrun got %0d exp 0", under_cnt); end
  endtask

  task automatic test_underrun();
    int under_cnt;
    int under_n;
    under_cnt = 0; under_n = -1;
    do_reset();
    write(1'b0, 16'h8000);
    while (n < 4 + 256 + 2) begin
      tick();
      if (n < 4 + 256 && bus.underrun === 1'b1) begin under_cnt++; under_n = n; end
      checks++; if (bus.underrun !== e_under) begin errors++; $display("FAIL ur_underrun n=%0d got %b exp %b", n, bus.underrun, e_under); end
    end
    checks++; if (under_cnt != 1) begin errors++; $display("FAIL ur_count got %0d exp 1", under_cnt); end
    checks++; if (under_n != 4 + 128) begin errors++; $display("FAIL ur_when got %0d exp %0d", under_n, 4 + 128); end
    checks++;
    if (bits.size() < 64) begin
      errors++; $display("FAIL ur_bitcount got %0d exp >= 64", bits.size());
    end else begin
      if (slot_word(0) !== {1'b0, 16'h8000, 15'h0}) begin
        errors++; $display("FAIL ur_left got %h exp %h", slot_word(0), {1'b0, 16'h8000, 15'h0});
      end
      checks++;
      if (slot_word(1) !== 32'h0) begin errors++; $display("FAIL ur_right got %h exp 0", slot_word(1)); end
    end
  endtask

  task automatic test_free_run();
    int   last_edge;
    int   dut_edges;
    int   model_edges;
    logic prev_lrck;
    last_edge = -1; dut_edges = 0; model_edges = 0;
    for (int i = 0; i < 1000; i++) begin
      prev_lrck = bus.lrck;
      tick();
      if (e_edge) model_edges++;
      checks++; if (bus.bclk !== e_bclk) begin errors++; $display("FAIL free_bclk n=%0d got %b exp %b", n, bus.bclk, e_bclk); end
      checks++; if (bus.lrck !== e_lrck) begin errors++; $display("FAIL free_lrck n=%0d got %b exp %b", n, bus.lrck, e_lrck); end
      if (bus.l_r_edge === 1'b1) begin
        dut_edges++;
        checks++;
        if (bus.lrck === prev_lrck) begin errors++; $display("FAIL free_edge_lrck n=%0d lrck %b unchanged", n, bus.lrck); end
        if (last_edge >= 0) begin
          checks++;
          if (n - last_edge != 128) begin errors++; $display("FAIL free_edge_gap got %0d exp 128", n - last_edge); end
        end
        last_edge = n;
      end
    end
    checks++; if (dut_edges != model_edges) begin errors++; $display("FAIL free_edge_count got %0d exp %0d", dut_edges, model_edges); end
  endtask

  task automatic test_same_cycle();
    int under_cnt;
    under_cnt = 0;
    do_reset();
    write(1'b0, 16'h0001);
    write(1'b1, 16'h5555);
    tick();
    write(1'b0, 16'h7FFF);
    while (n < 392) begin
      if (n == 139) write(1'b1, 16'h0AAA);
      else tick();
      if (bus.underrun === 1'b1) under_cnt++;
      checks++; if (bus.sdata !== e_sdata) begin errors++; $display("FAIL same_sdata n=%0d got %b exp %b", n, bus.sdata, e_sdata); end
    end
    checks++; if (under_cnt != 0) begin errors++; $display("FAIL same_underrun got %0d exp 0", under_cnt); end
    checks++;
    if (bits.size() < 96) begin
      errors++; $display("FAIL same_bitcount got %0d exp >= 96", bits.size());
    end else begin
      if (slot_word(0) !== {1'b0, 16'h0001, 15'h0}) begin
        errors++; $display("FAIL same_left1 got %h exp %h", slot_word(0), {1'b0, 16'h0001, 15'h0});
      end
      checks++;
      if (slot_word(1) !== {1'b0, 16'h5555, 15'h0}) begin
        errors++; $display("FAIL same_right1 got %h exp %h", slot_word(1), {1'b0, 16'h5555, 15'h0});
      end
      checks++;
      if (slot_word(2) !== {1'b0, 16'h7FFF, 15'h0}) begin
        errors++; $display("FAIL same_left2 got %h exp %h", slot_word(2), {1'b0, 16'h7FFF, 15'h0});
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    write(1'b0, 16'h1111);
    write(1'b1, 16'h2222);
    while (n < 164) tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.bclk !== 1'b0) begin errors++; $display("FAIL mid_bclk got %b exp 0", bus.bclk); end
    checks++; if (bus.lrck !== 1'b1) begin errors++; $display("FAIL mid_lrck got %b exp 1", bus.lrck); end
    checks++; if (bus.sdata !== 1'b0) begin errors++; $display("FAIL mid_sdata got %b exp 0", bus.sdata); end
    checks++; if (bus.l_r_edge !== 1'b0) begin errors++; $display("FAIL mid_edge got %b exp 0", bus.l_r_edge); end
    checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL mid_underrun got %b exp 0", bus.underrun); end
    reset = 1'b1;
    write(1'b0, 16'hBEEF);
    write(1'b1, 16'h0F0F);
    while (n < 4 + 256 + 2) begin
      tick();
      checks++; if (bus.sdata !== e_sdata) begin errors++; $display("FAIL mid_sdata_run n=%0d got %b exp %b", n, bus.sdata, e_sdata); end
      checks++; if (bus.underrun !== e_under) begin errors++; $display("FAIL mid_underrun_run n=%0d got %b exp %b", n, bus.underrun, e_under); end
    end
    checks++;
    if (bits.size() < 64) begin
      errors++; $display("FAIL mid_bitcount got %0d exp >= 64", bits.size());
    end else begin
      if (slot_word(0) !== {1'b0, 16'hBEEF, 15'h0}) begin
        errors++; $display("FAIL mid_left got %h exp %h", slot_word(0), {1'b0, 16'hBEEF, 15'h0});
      end
      checks++;
      if (slot_word(1) !== {1'b0, 16'h0F0F, 15'h0}) begin
        errors++; $display("FAIL mid_right got %h exp %h", slot_word(1), {1'b0, 16'h0F0F, 15'h0});
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int i = 0; i < 600; i++) begin
        if (is_slot_start(n + 1) && $urandom_range(1, 0) == 1) begin
          bus.sample_valid = 1'b1; bus.sample_ch = 1'(slot_ch(n + 1));
        end else begin
          bus.sample_valid = ($urandom_range(15, 0) == 0); bus.sample_ch = 1'($urandom_range(1, 0));
        end
        bus.sample_in = 16'($urandom);
        tick();
        bus.sample_valid = 1'b0;
        checks++; if (bus.bclk !== e_bclk) begin errors++; $display("FAIL rnd_bclk n=%0d got %b exp %b", n, bus.bclk, e_bclk); end
        checks++; if (bus.lrck !== e_lrck) begin errors++; $display("FAIL rnd_lrck n=%0d got %b exp %b", n, bus.lrck, e_lrck); end
        checks++; if (bus.sdata !== e_sdata) begin errors++; $display("FAIL rnd_sdata n=%0d got %b exp %b", n, bus.sdata, e_sdata); end
        checks++; if (bus.l_r_edge !== e_edge) begin errors++; $display("FAIL rnd_edge n=%0d got %b exp %b", n, bus.l_r_edge, e_edge); end
        checks++; if (bus.underrun !== e_under) begin errors++; $display("FAIL rnd_underrun n=%0d got %b exp %b", n, bus.underrun, e_under); end
      end
    end
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_ch    = 1'b0;
    bus.sample_in    = '0;
    n = 0; m_pend = '0; m_word = '0; m_hold[0] = '0; m_hold[1] = '0;
    test_reset();
    test_stream();
    test_underrun();
    test_free_run();
    test_same_cycle();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter BCLK_HALF, default 2, meaning clk cycles per BCLK half-period (legal range >= 1).
REQ-002 SHALL have parameter SLOT_BITS, default 32, meaning BCLK periods per channel slot (legal range >= 18).
REQ-003 SHALL have port: clk  input  1  system clock; all logic on posedge clk.
REQ-004 SHALL have port: reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: sample_in  input  16  signed two's-complement audio sample.
REQ-006 SHALL have port: sample_valid  input  1  single-cycle write strobe for sample_in.
REQ-007 SHALL have port: sample_ch  input  1  write target: 0 = left, 1 = right.
REQ-008 SHALL have port: bclk  output  1  I2S bit clock.
REQ-009 SHALL have port: lrck  output  1  I2S word select: 0 = left slot, 1 = right slot.
REQ-010 SHALL have port: sdata  output  1  I2S serial data.
REQ-011 SHALL have port: l_r_edge  output  1  one-clk pulse on every lrck transition; drives the filter sample strobe.
REQ-012 SHALL have port: underrun  output  1  one-clk pulse when a slot starts with no fresh sample for that channel.

Function
REQ-013 SHALL register all outputs; no combinational path from inputs to outputs.
REQ-014 Divider div_cnt SHALL count 0..BCLK_HALF-1; at BCLK_HALF-1 it wraps to 0 and bclk toggles.
REQ-015 A "falling event" SHALL be the clk cycle in which bclk toggles 1->0; all data, lrck and counter updates occur only on falling events.
REQ-016 bit_cnt SHALL increment on each falling event, wrapping SLOT_BITS-1 -> 0; lrck toggles on the wrapping falling event.
REQ-017 At each slot start (the falling event where bit_cnt becomes 0), the shift register SHALL load the hold register of the new channel (lrck new value).
REQ-018 sdata SHALL equal shift bit [16-k] while bit_cnt = k for k = 1..16 (MSB first, one-bit I2S delay), and 0 for k = 0 and k = 17..SLOT_BITS-1.
REQ-019 sample_valid SHALL write sample_in to the hold register selected by sample_ch and set that channel's pending flag.
REQ-020 A slot load SHALL clear that channel's pending flag; if the flag was clear before the load, underrun pulses for that cycle and the stale hold value is retransmitted.
REQ-021 If sample_valid targets the channel being loaded in the same cycle, the pre-write hold value SHALL be loaded and underrun evaluated on the pre-write flag; the new value is stored with pending set for the next slot of that channel.
REQ-022 l_r_edge SHALL be high exactly in the clk cycle after the edge on which lrck toggles, i.e. concurrent with the new lrck value, for both transition directions.
REQ-023 lrck period SHALL be 4*BCLK_HALF*SLOT_BITS clk cycles; bclk duty cycle SHALL be exactly 50%.
REQ-024 Sample values SHALL be transmitted bit-exact; no rounding, saturation or sign manipulation.

Reset
REQ-025 While reset = 0: bclk = 0, lrck = 1, sdata = 0, l_r_edge = 0, underrun = 0, div_cnt = 0, bit_cnt = SLOT_BITS-1, hold registers = 0, pending flags = 0, shift register = 0.
REQ-026 The first falling event after reset release SHALL occur after 2*BCLK_HALF clk edges and start a left slot (lrck 1->0, l_r_edge pulse).
REQ-027 Reset asserted mid-slot SHALL return all state to REQ-025 values on the next clk edge, discarding the partial word.

Verification (BCLK_HALF=2, SLOT_BITS=32)
REQ-028 Hold reset 3 cycles -> bclk=0, lrck=1, sdata=0, l_r_edge=0, underrun=0 throughout.
REQ-029 Write left 0xA5C3, right 0x1234 before clk edge 4 -> lrck falls at edge 4 with l_r_edge pulse; bits sampled on bclk rising edges in left slot = 0xA5C3 MSB first then 15 zeros; right slot = 0x1234; no underrun.
REQ-030 Write left 0x8000 only -> left slot bits = 1 followed by 15 zeros; right slot sends 0x0000 and underrun pulses once at right slot start.
REQ-031 Free run 1000 clk -> l_r_edge pulses every 128 clk, each exactly one cycle wide, each coincident with a new lrck value; bclk period 4 clk.
REQ-032 Write left 0x7FFF in the same cycle as the left slot load (prior hold 0x0001 pending) -> current slot sends 0x0001, next left slot sends 0x7FFF, no underrun either slot.
REQ-033 Assert reset at bit_cnt=8 of a right slot -> next edge outputs match REQ-025; after release, first word sent is left from freshly written hold, not the discarded word.
